// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: register file with write-to-read bypass and a busy-bit
// scoreboard that flags RAW/WAW hazards for the issue stage.
module register_file_scoreboard #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   RS1,
    input  logic [AW-1:0]   RS2,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    input  logic            RegWrite,
    input  logic [AW-1:0]   RD,
    input  logic [XLEN-1:0] WriteData,
    input  logic            IssueValid,
    input  logic [AW-1:0]   IssueRD,
    output logic            RS1Busy,
    output logic            RS2Busy,
    output logic            Stall,
    input  logic [AW-1:0]   DbgAddr,
    output logic [XLEN-1:0] DbgData,
    output logic [AW:0]     PendingCount
);
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_next;
    logic            bypass, issue_waw;

    // Register 0 is never written or marked busy, so it reads as 0 without a special case.
    assign bypass    = reset && RegWrite && RD != '0;
    assign ReadData1 = (bypass && RD == RS1) ? WriteData : regs[RS1];
    assign ReadData2 = (bypass && RD == RS2) ? WriteData : regs[RS2];
    assign DbgData   = regs[DbgAddr];
    assign RS1Busy   = busy[RS1] && !(RegWrite && RD == RS1);
    assign RS2Busy   = busy[RS2] && !(RegWrite && RD == RS2);
    assign issue_waw = IssueValid && IssueRD != '0 && busy[IssueRD] && !(RegWrite && RD == IssueRD);
    assign Stall     = RS1Busy || RS2Busy || issue_waw;

    // A new issue overrides a same-edge writeback clear of the same register.
    assign busy_next = (busy & ~(RegWrite ? NREG'(1) << RD : '0))
                     | ((IssueValid && !Stall && IssueRD != '0) ? NREG'(1) << IssueRD : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= '0;
            PendingCount <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            busy         <= busy_next;
            PendingCount <= (AW+1)'($countones(busy_next));
            if (RegWrite && RD != '0) regs[RD] <= WriteData;
        end
    end
endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb_register_file_scoreboard: directed and random stimulus against an array-based
// reference model; expectations are queued and checked by an independent monitor.
module tb_register_file_scoreboard;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    logic            clk = 0;
    logic            reset;
    logic [AW-1:0]   RS1, RS2, RD, IssueRD, DbgAddr;
    logic            RegWrite, IssueValid;
    logic [XLEN-1:0] WriteData, ReadData1, ReadData2, DbgData;
    logic            RS1Busy, RS2Busy, Stall;
    logic [AW:0]     PendingCount;

    always #5 clk = ~clk;

    register_file_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .reset(reset), .RS1(RS1), .RS2(RS2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .IssueValid(IssueValid), .IssueRD(IssueRD),
        .RS1Busy(RS1Busy), .RS2Busy(RS2Busy), .Stall(Stall),
        .DbgAddr(DbgAddr), .DbgData(DbgData), .PendingCount(PendingCount)
    );

    typedef struct {
        logic [XLEN-1:0] rd1, rd2, dbg;
        logic            b1, b2, st;
        int              pc;
    } exp_t;

    exp_t            q[$];
    event            ev;
    int              checks = 0, errors = 0;
    logic [XLEN-1:0] mregs [NREG];
    bit              mbusy [NREG];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial forever begin
        exp_t e;
        @(ev);
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_underflow at %0t", $time);
        end else begin
            e = q.pop_front();
            chk("ReadData1", ReadData1, e.rd1);
            chk("ReadData2", ReadData2, e.rd2);
            chk("DbgData", DbgData, e.dbg);
            chk("RS1Busy", XLEN'(RS1Busy), XLEN'(e.b1));
            chk("RS2Busy", XLEN'(RS2Busy), XLEN'(e.b2));
            chk("Stall", XLEN'(Stall), XLEN'(e.st));
            chk("PendingCount", XLEN'(PendingCount), XLEN'(e.pc));
        end
    end

    task automatic cycle(input logic r, input logic rw, input logic [AW-1:0] rd,
                         input logic [XLEN-1:0] wd, input logic iv, input logic [AW-1:0] ird,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] dbg);
        exp_t e;
        int   n;
        @(negedge clk);
        reset = r; RegWrite = rw; RD = rd; WriteData = wd;
        IssueValid = iv; IssueRD = ird; RS1 = rs1; RS2 = rs2; DbgAddr = dbg;
        if (!r) begin
            for (int i = 0; i < NREG; i++) begin
                mregs[i] = '0;
                mbusy[i] = 0;
            end
        end
        n = 0;
        for (int i = 0; i < NREG; i++) n += int'(mbusy[i]);
        e.pc  = n;
        e.dbg = mregs[dbg];
        if (!r) begin
            e.rd1 = '0; e.rd2 = '0; e.b1 = 0; e.b2 = 0; e.st = 0;
        end else begin
            e.rd1 = (rs1 == 0) ? '0 : (rw && rd == rs1) ? wd : mregs[rs1];
            e.rd2 = (rs2 == 0) ? '0 : (rw && rd == rs2) ? wd : mregs[rs2];
            e.b1  = rs1 != 0 && mbusy[rs1] && !(rw && rd == rs1);
            e.b2  = rs2 != 0 && mbusy[rs2] && !(rw && rd == rs2);
            e.st  = e.b1 || e.b2 || (iv && ird != 0 && mbusy[ird] && !(rw && rd == ird));
        end
        q.push_back(e);
        ->ev;
        @(posedge clk);
        if (r) begin
            if (rw && rd != 0) mregs[rd] = wd;
            if (rw) mbusy[rd] = 0;
            if (iv && !e.st && ird != 0) mbusy[ird] = 1;
        end
    endtask

    task automatic idle(input logic [AW-1:0] rs1, input logic [AW-1:0] dbg);
        cycle(1, 0, 0, '0, 0, 0, rs1, 0, dbg);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            mregs[i] = '0;
            mbusy[i] = 0;
        end
        reset = 0; RegWrite = 0; RD = 0; WriteData = '0;
        IssueValid = 0; IssueRD = 0; RS1 = 0; RS2 = 0; DbgAddr = 0;
        cycle(0, 1, 5, 64'h55, 1, 6, 5, 6, 5);
        cycle(0, 0, 0, '0, 0, 0, 0, 0, 0);
        // Write R5 and issue R9, then reset between edges: state must vanish at once.
        cycle(1, 1, 5, 64'hAA, 1, 9, 0, 0, 5);
        idle(0, 5);
        cycle(0, 1, 6, 64'h77, 1, 2, 5, 9, 5);
        cycle(1, 1, 7, 64'h1234, 0, 0, 7, 0, 7);
        idle(7, 7);
        cycle(1, 0, 0, '0, 1, 3, 0, 0, 0);
        cycle(1, 0, 0, '0, 0, 0, 3, 0, 3);
        cycle(1, 1, 3, 64'hBEEF, 0, 0, 3, 0, 3);
        idle(3, 3);
        cycle(1, 0, 0, '0, 1, 4, 0, 0, 0);
        cycle(1, 0, 0, '0, 1, 4, 0, 4, 4);
        cycle(1, 1, 4, 64'h44, 1, 4, 0, 0, 4);
        idle(4, 4);
        cycle(1, 1, 4, 64'h45, 0, 0, 4, 0, 4);
        cycle(1, 1, 0, 64'hFF, 1, 0, 0, 0, 0);
        idle(0, 0);
        for (int i = 1; i < NREG; i++) cycle(1, 0, 0, '0, 1, AW'(i), 0, 0, 0);
        idle(0, 0);
        for (int i = 1; i < NREG; i++) cycle(1, 1, AW'(i), XLEN'(i * 3), 0, 0, 0, 0, AW'(i));
        idle(0, 1);
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(99) != 0), $urandom_range(1), AW'($urandom), {$urandom, $urandom},
                  $urandom_range(1), AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
        end
        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file_scoreboard.md
REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 Parameter XLEN, default 64: register data width in bits.
REQ-002 Parameter NREG, default 32: register count, power of two, 2..64; AW = log2(NREG) is derived internally, not user-set.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 RS1  input  AW  read port 1 register address.
REQ-006 RS2  input  AW  read port 2 register address.
REQ-007 ReadData1  output  XLEN  read port 1 data, combinational.
REQ-008 ReadData2  output  XLEN  read port 2 data, combinational.
REQ-009 RegWrite  input  1  writeback valid this cycle.
REQ-010 RD  input  AW  writeback destination address.
REQ-011 WriteData  input  XLEN  writeback data.
REQ-012 IssueValid  input  1  an instruction writing IssueRD issues this cycle.
REQ-013 IssueRD  input  AW  destination of the issuing instruction.
REQ-014 RS1Busy  output  1  RS1 has an outstanding write not yet available.
REQ-015 RS2Busy  output  1  RS2 has an outstanding write not yet available.
REQ-016 Stall  output  1  issuing stage must hold (RAW or WAW hazard).
REQ-017 DbgAddr  input  AW  debug observation address.
REQ-018 DbgData  output  XLEN  contents of register DbgAddr, no bypass.
REQ-019 PendingCount  output  AW+1  number of registers currently marked busy, registered.

Function
REQ-020 Register 0 SHALL read as 0 on every port and SHALL never be written or marked busy.
REQ-021 On a rising edge with RegWrite=1 and RD!=0, Registers[RD] SHALL take WriteData.
REQ-022 ReadDataN SHALL equal WriteData when RegWrite=1, RD=RSN and RSN!=0 (same-cycle write-to-read bypass); otherwise Registers[RSN].
REQ-023 Busy bit busy[r] SHALL set on a rising edge when IssueValid=1, Stall=0 and IssueRD=r!=0.
REQ-024 Busy bit busy[r] SHALL clear on a rising edge when RegWrite=1 and RD=r, unless REQ-023 sets it in the same edge (set wins: newer issue).
REQ-025 RSNBusy SHALL be busy[RSN] AND NOT (RegWrite=1 AND RD=RSN); 0 when RSN=0.
REQ-026 Stall SHALL be RS1Busy OR RS2Busy OR (IssueValid AND IssueRD!=0 AND busy[IssueRD] AND NOT (RegWrite AND RD=IssueRD)).
REQ-027 When Stall=1 the issue SHALL be ignored (no busy bit set); writeback SHALL proceed regardless of Stall.
REQ-028 PendingCount SHALL update one cycle after busy changes, equal to popcount of the next-state busy vector; never exceeds NREG-1.
REQ-029 RegWrite to a register whose busy bit is clear SHALL still write data (untracked writes allowed) and SHALL leave busy unchanged.
REQ-030 DbgData SHALL be Registers[DbgAddr] (0 for address 0), combinational, independent of bypass.

Reset
REQ-031 While reset=0, all registers, all busy bits and PendingCount SHALL be 0 immediately (no clock required); ReadData1/2, DbgData, RS1Busy, RS2Busy, Stall SHALL read 0.
REQ-032 While reset=0, RegWrite and IssueValid SHALL be ignored; bypass SHALL be suppressed.
REQ-033 Reset asserted mid-operation SHALL discard all pending busy state; first edge after release behaves as from power-up.

Verification
REQ-034 Reset: write R5=0xAA, assert reset=0 between edges -> DbgAddr=5 reads 0 without a clock edge, PendingCount=0.
REQ-035 Bypass: RegWrite=1, RD=7, WriteData=0x1234, RS1=7, RS2=0 same cycle -> ReadData1=0x1234, ReadData2=0; next cycle ReadData1=0x1234 from array.
REQ-036 RAW scoreboard: issue IssueRD=3; next cycle RS1=3 -> RS1Busy=1, Stall=1, PendingCount=1; cycle with RegWrite RD=3 -> RS1Busy=0, Stall=0; after edge PendingCount=0.
REQ-037 WAW: busy[4]=1, IssueValid IssueRD=4, no writeback -> Stall=1, busy unchanged; same with RegWrite RD=4 -> Stall=0, busy[4] remains 1 (set wins), PendingCount=1.
REQ-038 x0: IssueRD=0 and RegWrite RD=0 WriteData=0xFF -> no busy set, Stall=0, ReadData1 with RS1=0 reads 0, PendingCount=0.
REQ-039 Fill: issue registers 1..NREG-1 on consecutive cycles with no reads -> PendingCount=NREG-1; write all back -> PendingCount=0.
